// File: rtl/haar_stage_database_streamer.sv
// haar_stage_database_streamer
//   Streams one stage's Haar classifier database out of a synchronous ROM as
//   a valid/ready beat stream. Each beat carries the word plus its indices and
//   end flags. The flags are decided when the ROM read is issued and travel
//   with the word through a 2-entry skid buffer.
//
//   ROM layout at BASE_ADDR: N, stage threshold, then N*CLASSIFIER_WORDS
//   classifier words in classifier-major order.
//
// Ports
//   clk_fpga, reset_fpga     clock, synchronous active-high reset
//   start                    pulse that starts streaming; ignored while busy
//   rom_read/rom_address     ROM read strobe and address
//   rom_readdata             ROM data, valid the cycle after rom_read
//   o_valid/i_ready          beat handshake
//   data, index_*, end_*     beat payload
//   stage_threshold          threshold of the last streamed stage
//   o_busy, o_done           busy level, 1-cycle completion pulse
//   o_checksum_error         checksum mismatch (0 when the feature is off)
//
// Build option
//   DATABASE_CHECKSUM_EN     read one trailing checksum word after the last
//                            classifier word and compare it with the 12-bit
//                            sum of all streamed words.
module haar_stage_database_streamer #(
  parameter int DATA_WIDTH_12        = 12,
  parameter int DATA_WIDTH_16        = 16,
  parameter int CLASSIFIER_WORDS     = 18,
  parameter int CLASSIFIERS_PER_TREE = 1,
  parameter int BASE_ADDR            = 0
) (
  input  logic                     clk_fpga,
  input  logic                     reset_fpga,
  input  logic                     start,
  output logic                     rom_read,
  output logic [DATA_WIDTH_16-1:0] rom_address,
  input  logic [DATA_WIDTH_12-1:0] rom_readdata,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [DATA_WIDTH_12-1:0] data,
  output logic [DATA_WIDTH_12-1:0] index_database,
  output logic [DATA_WIDTH_12-1:0] index_classifier,
  output logic [DATA_WIDTH_12-1:0] index_tree,
  output logic                     end_single_classifier,
  output logic                     end_tree,
  output logic                     end_database,
  output logic [DATA_WIDTH_12-1:0] stage_threshold,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_checksum_error
);

  localparam int DW = DATA_WIDTH_12;
  localparam int AW = DATA_WIDTH_16;
  localparam logic [AW-1:0] BASE = AW'(BASE_ADDR);

  typedef struct packed {
    logic [DW-1:0] data;
    logic [DW-1:0] idx_db;
    logic [DW-1:0] idx_cls;
    logic [DW-1:0] idx_tree;
    logic          end_sc;
    logic          end_tr;
    logic          end_db;
  } beat_t;

  typedef enum logic [2:0] {IDLE, HDR, THR, STREAM, DRAIN, DONE} state_t;
  // What the read issued last cycle was for; its data is on rom_readdata now.
  typedef enum logic [2:0] {RD_NONE, RD_HDR, RD_THR, RD_CLS, RD_CHK} rd_tag_t;

  state_t  state_q, state_d;
  rd_tag_t rd_tag_q, rd_tag_d;

  beat_t         buf_q [2];
  logic [1:0]    cnt_q;
  beat_t         iss_meta_q, meta, push_beat;
  logic [DW-1:0] n_q, idx_db_q, idx_cls_q, idx_tree_q, tree_pos_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] thr_q;
  logic          done_q;

  logic       pop, push, inflight, issue_cls, fin, drained;
  logic [1:0] cnt_after, occ;
  logic       last_word, last_cls, last_in_tree;

`ifdef DATABASE_CHECKSUM_EN
  logic          chk_issue, chk_issued_q, chk_have_q, cerr_q;
  logic [DW-1:0] chk_word_q, chk_word, sum_q;
`endif

  always_comb begin
    pop       = (cnt_q != 2'd0) && i_ready;
    inflight  = (rd_tag_q == RD_CLS);
    push      = inflight;
    cnt_after = cnt_q - {1'b0, pop};
    // Counting this cycle's pop lets a read issue every cycle while the
    // buffer plus in-flight read never exceeds two words.
    occ       = cnt_after + {1'b0, inflight};
    drained   = !inflight && (cnt_after == 2'd0);

    last_word    = (idx_db_q == DW'(CLASSIFIER_WORDS - 1));
    last_cls     = (idx_cls_q == n_q - DW'(1));
    last_in_tree = (tree_pos_q == DW'(CLASSIFIERS_PER_TREE - 1));

    meta          = '0;
    meta.idx_db   = idx_db_q;
    meta.idx_cls  = idx_cls_q;
    meta.idx_tree = idx_tree_q;
    meta.end_sc   = last_word;
    meta.end_tr   = last_word && (last_in_tree || last_cls);
    meta.end_db   = last_word && last_cls;

    push_beat      = iss_meta_q;
    push_beat.data = rom_readdata;
  end

`ifdef DATABASE_CHECKSUM_EN
  assign chk_word = (rd_tag_q == RD_CHK) ? rom_readdata : chk_word_q;
`endif

  always_comb begin
    state_d     = state_q;
    rd_tag_d    = RD_NONE;
    rom_read    = 1'b0;
    rom_address = '0;
    issue_cls   = 1'b0;
    fin         = 1'b0;
`ifdef DATABASE_CHECKSUM_EN
    chk_issue   = 1'b0;
`endif
    case (state_q)
      IDLE: if (start) state_d = HDR;
      HDR: begin
        rom_read    = 1'b1;
        rom_address = BASE;
        rd_tag_d    = RD_HDR;
        state_d     = THR;
      end
      THR: begin
        // rom_readdata holds N (header read of the previous cycle)
        rom_read    = 1'b1;
        rom_address = BASE + AW'(1);
        rd_tag_d    = RD_THR;
`ifdef DATABASE_CHECKSUM_EN
        state_d     = (rom_readdata == '0) ? DRAIN : STREAM;
`else
        state_d     = (rom_readdata == '0) ? DONE : STREAM;
`endif
      end
      STREAM: if (occ < 2'd2) begin
        rom_read    = 1'b1;
        rom_address = addr_q;
        rd_tag_d    = RD_CLS;
        issue_cls   = 1'b1;
        if (meta.end_db) state_d = DRAIN;
      end
      DRAIN: begin
`ifdef DATABASE_CHECKSUM_EN
        if (!chk_issued_q) begin
          rom_read    = 1'b1;
          rom_address = addr_q;
          rd_tag_d    = RD_CHK;
          chk_issue   = 1'b1;
        end
        if (drained && (chk_have_q || rd_tag_q == RD_CHK)) begin
          fin     = 1'b1;
          state_d = IDLE;
        end
`else
        if (drained) begin
          fin     = 1'b1;
          state_d = IDLE;
        end
`endif
      end
      DONE: begin
        fin     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_fpga) begin
    if (reset_fpga) begin
      state_q    <= IDLE;
      rd_tag_q   <= RD_NONE;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
      cnt_q      <= 2'd0;
      iss_meta_q <= '0;
      n_q        <= '0;
      idx_db_q   <= '0;
      idx_cls_q  <= '0;
      idx_tree_q <= '0;
      tree_pos_q <= '0;
      addr_q     <= '0;
      thr_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_tag_q <= rd_tag_d;
      done_q   <= fin;

      if (rd_tag_q == RD_THR) thr_q <= rom_readdata;

      if (state_q == THR) begin
        n_q        <= rom_readdata;
        addr_q     <= BASE + AW'(2);
        idx_db_q   <= '0;
        idx_cls_q  <= '0;
        idx_tree_q <= '0;
        tree_pos_q <= '0;
      end

      if (issue_cls) begin
        iss_meta_q <= meta;
        addr_q     <= addr_q + AW'(1);
        if (last_word) begin
          idx_db_q  <= '0;
          idx_cls_q <= idx_cls_q + DW'(1);
          if (last_in_tree) begin
            tree_pos_q <= '0;
            idx_tree_q <= idx_tree_q + DW'(1);
          end else begin
            tree_pos_q <= tree_pos_q + DW'(1);
          end
        end else begin
          idx_db_q <= idx_db_q + DW'(1);
        end
      end

      case ({push, pop})
        2'b10: begin
          buf_q[cnt_q[0]] <= push_beat;
          cnt_q           <= cnt_q + 2'd1;
        end
        2'b01: begin
          buf_q[0] <= buf_q[1];
          cnt_q    <= cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd2) begin
            buf_q[0] <= buf_q[1];
            buf_q[1] <= push_beat;
          end else begin
            buf_q[0] <= push_beat;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DATABASE_CHECKSUM_EN
  always_ff @(posedge clk_fpga) begin
    if (reset_fpga) begin
      chk_issued_q <= 1'b0;
      chk_have_q   <= 1'b0;
      chk_word_q   <= '0;
      sum_q        <= '0;
      cerr_q       <= 1'b0;
    end else begin
      if (state_q == IDLE && start) begin
        chk_issued_q <= 1'b0;
        chk_have_q   <= 1'b0;
        sum_q        <= '0;
        cerr_q       <= 1'b0;
      end
      if (chk_issue) chk_issued_q <= 1'b1;
      if (rd_tag_q == RD_CHK) begin
        chk_word_q <= rom_readdata;
        chk_have_q <= 1'b1;
      end
      if (push) sum_q <= sum_q + rom_readdata;
      // no push can coincide with fin, so sum_q is complete here
      if (fin) cerr_q <= (chk_word != sum_q);
    end
  end
  assign o_checksum_error = cerr_q;
`else
  assign o_checksum_error = 1'b0;
`endif

  assign o_valid               = (cnt_q != 2'd0);
  assign data                  = buf_q[0].data;
  assign index_database        = buf_q[0].idx_db;
  assign index_classifier      = buf_q[0].idx_cls;
  assign index_tree            = buf_q[0].idx_tree;
  assign end_single_classifier = buf_q[0].end_sc;
  assign end_tree              = buf_q[0].end_tr;
  assign end_database          = buf_q[0].end_db;
  assign stage_threshold       = thr_q;
  assign o_busy                = (state_q != IDLE);
  assign o_done                = done_q;

endmodule

// File: tb/tb_haar_stage_database_streamer.sv
// Bench for haar_stage_database_streamer. Two instances share one ROM image:
// A (BASE 0, 1 classifier per tree) and B (BASE 256, 2 classifiers per tree).
// Expected beats are generated from the ROM contents by a flat model.
module tb_haar_stage_database_streamer;
  localparam int W = 18;

  logic clk_fpga = 1'b0;
  logic reset_fpga;
  always #5 clk_fpga = ~clk_fpga;

  logic [11:0] mem [0:1023];

  logic        start_a, start_b, ready_a, ready_b;
  logic        rom_read_a, rom_read_b;
  logic [15:0] rom_address_a, rom_address_b;
  logic [11:0] rd_a, rd_b;
  logic        vld_a, vld_b, esc_a, esc_b, etr_a, etr_b, edb_a, edb_b;
  logic [11:0] data_a, data_b, idb_a, idb_b, icl_a, icl_b, itr_a, itr_b, thr_a, thr_b;
  logic        busy_a, busy_b, done_a, done_b, cerr_a, cerr_b;

  haar_stage_database_streamer #(.CLASSIFIERS_PER_TREE(1), .BASE_ADDR(0)) dut_a (
    .clk_fpga(clk_fpga), .reset_fpga(reset_fpga), .start(start_a),
    .rom_read(rom_read_a), .rom_address(rom_address_a), .rom_readdata(rd_a),
    .o_valid(vld_a), .i_ready(ready_a), .data(data_a), .index_database(idb_a),
    .index_classifier(icl_a), .index_tree(itr_a), .end_single_classifier(esc_a),
    .end_tree(etr_a), .end_database(edb_a), .stage_threshold(thr_a),
    .o_busy(busy_a), .o_done(done_a), .o_checksum_error(cerr_a));

  haar_stage_database_streamer #(.CLASSIFIERS_PER_TREE(2), .BASE_ADDR(256)) dut_b (
    .clk_fpga(clk_fpga), .reset_fpga(reset_fpga), .start(start_b),
    .rom_read(rom_read_b), .rom_address(rom_address_b), .rom_readdata(rd_b),
    .o_valid(vld_b), .i_ready(ready_b), .data(data_b), .index_database(idb_b),
    .index_classifier(icl_b), .index_tree(itr_b), .end_single_classifier(esc_b),
    .end_tree(etr_b), .end_database(edb_b), .stage_threshold(thr_b),
    .o_busy(busy_b), .o_done(done_b), .o_checksum_error(cerr_b));

  // ROM: data valid only the cycle after a read, garbage otherwise
  always @(posedge clk_fpga) begin
    rd_a <= rom_read_a ? mem[rom_address_a[9:0]] : 12'($urandom);
    rd_b <= rom_read_b ? mem[rom_address_b[9:0]] : 12'($urandom);
  end

  logic [50:0] beat_a, beat_b;
  logic [83:0] outs_a, outs_b;
  assign beat_a = {data_a, idb_a, icl_a, itr_a, esc_a, etr_a, edb_a};
  assign beat_b = {data_b, idb_b, icl_b, itr_b, esc_b, etr_b, edb_b};
  assign outs_a = {rom_read_a, rom_address_a, vld_a, beat_a, thr_a, busy_a, done_a, cerr_a};
  assign outs_b = {rom_read_b, rom_address_b, vld_b, beat_b, thr_b, busy_b, done_b, cerr_b};

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Writes the checksum word (sum of the classifier words) after the database
  task automatic set_chk(input int base, input int delta);
    int n;
    logic [11:0] s;
    n = int'(mem[base]);
    s = '0;
    for (int i = 0; i < n * W; i++) s = s + mem[base + 2 + i];
    mem[base + 2 + n * W] = s + 12'(delta);
  endtask

  task automatic build_model(input int base, input int cpt, output logic [50:0] q[$],
                             output logic exp_cerr);
    int n;
    logic [11:0] s;
    n = int'(mem[base]);
    s = '0;
    q = {};
    for (int c = 0; c < n; c++)
      for (int w = 0; w < W; w++) begin
        logic [11:0] d;
        logic esc, etr, edb;
        d   = mem[base + 2 + c * W + w];
        s   = s + d;
        esc = (w == W - 1);
        etr = esc && (((c + 1) % cpt == 0) || (c == n - 1));
        edb = esc && (c == n - 1);
        q.push_back({d, 12'(w), 12'(c), 12'(c / cpt), esc, etr, edb});
      end
`ifdef DATABASE_CHECKSUM_EN
    exp_cerr = (mem[base + 2 + n * W] != s);
`else
    exp_cerr = 1'b0;
`endif
  endtask

  function automatic logic ready_pat(input int mode, input int c);
    logic [3:0] tog;
    tog = 4'b1001;
    case (mode)
      0: return 1'b1;
      1: return tog[c % 4];
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // mode 0: ready high, 1: ready 1,0,0,1 repeating, 2: random ready
  task automatic run_db(input bit s, input int mode);
    logic [50:0] q[$];
    logic [50:0] beat, prev_beat;
    logic exp_cerr, v, rdy, busy, done, cerr, rr, prev_stall, got_done;
    logic [15:0] addr;
    logic [11:0] thr;
    int base, cpt, n, beats, last_xfer, reads, first_v, exp_done;
    base = s ? 256 : 0;
    cpt  = s ? 2 : 1;
    n    = int'(mem[base]);
    build_model(base, cpt, q, exp_cerr);
    beats = 0; last_xfer = 0; reads = 0; first_v = -1;
    prev_stall = 1'b0; got_done = 1'b0; prev_beat = '0;

    @(negedge clk_fpga);
    if (s) start_b = 1'b1; else start_a = 1'b1;
    for (int c = 1; c < 3000 && !got_done; c++) begin
      @(negedge clk_fpga);
      start_a = 1'b0;
      start_b = 1'b0;
      rdy = ready_pat(mode, c);
      if (s) ready_b = rdy; else ready_a = rdy;
      #1;
      v    = s ? vld_b : vld_a;
      beat = s ? beat_b : beat_a;
      busy = s ? busy_b : busy_a;
      done = s ? done_b : done_a;
      cerr = s ? cerr_b : cerr_a;
      thr  = s ? thr_b : thr_a;
      rr   = s ? rom_read_b : rom_read_a;
      addr = s ? rom_address_b : rom_address_a;

      if (c == 1) chk("hdr_read", {rr, addr}, {1'b1, 16'(base)});
      if (c == 2) chk("thr_read", {rr, addr}, {1'b1, 16'(base + 1)});
`ifdef DATABASE_CHECKSUM_EN
      if (c == 3) chk("first_read", {rr, addr}, {1'b1, 16'(base + 2)});
`else
      if (c == 3) chk("first_read", {rr, addr}, {n != 0, n != 0 ? 16'(base + 2) : 16'h0});
`endif
      if (c >= 3 && rr && reads < n * W) reads++;
      if (prev_stall) chk("hold", {v, beat}, {1'b1, prev_beat});
      if (v && first_v < 0) begin
        first_v = c;
        chk("first_valid_cyc", 32'(c), 32'd5);
      end
      if (v && rdy) begin
        if (q.size() == 0) chk("extra_beat", beat, 51'h0);
        else chk($sformatf("beat%0d", beats), beat, q.pop_front());
        if (mode == 0) chk("no_bubble", 32'(c), 32'(5 + beats));
        beats++;
        last_xfer = c;
      end
      if (reads - beats > 2) chk("occupancy", 32'(reads - beats), 32'd2);
      prev_stall = v && !rdy;
      prev_beat  = beat;
      if (done) begin
        got_done = 1'b1;
`ifdef DATABASE_CHECKSUM_EN
        exp_done = (n == 0) ? 5 : last_xfer + 1;
`else
        exp_done = (n == 0) ? 4 : last_xfer + 1;
`endif
        chk("done_cyc", 32'(c), 32'(exp_done));
        chk("done_busy", busy, 1'b0);
        chk("threshold", thr, mem[base + 1]);
        chk("cksum_err", cerr, exp_cerr);
      end else if (busy !== 1'b1) begin
        chk("busy", busy, 1'b1);
      end
    end
    if (!got_done) chk("done_timeout", 1'b0, 1'b1);
    chk("beats_left", 32'(q.size()), 32'd0);
    @(negedge clk_fpga);
    #1;
    chk("done_pulse", s ? {done_b, busy_b} : {done_a, busy_a}, 2'b00);
    chk("cerr_hold", s ? cerr_b : cerr_a, exp_cerr);
    if (s) ready_b = 1'b0; else ready_a = 1'b0;
  endtask

  initial begin
    logic [50:0] q[$];
    logic ec;
    logic [11:0] sv0, sv2;
    reset_fpga = 1'b1;
    start_a = 1'b0; start_b = 1'b0; ready_a = 1'b0; ready_b = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[0] = 12'd2;
    mem[1] = 12'h150;
    for (int i = 0; i < 36; i++) mem[2 + i] = 12'(i + 1);
    set_chk(0, 0);
    mem[256] = 12'd3;
    mem[257] = 12'($urandom);
    for (int i = 0; i < 54; i++) mem[258 + i] = 12'($urandom);
    set_chk(256, 0);

    repeat (3) @(negedge clk_fpga);
    #1;
    chk("reset_a", outs_a, 84'h0);
    chk("reset_b", outs_b, 84'h0);
    reset_fpga = 1'b0;

    run_db(0, 0);             // directed database, full rate
    run_db(0, 1);             // same database, ready 1,0,0,1
    run_db(1, 0);             // two classifiers per tree, N=3
    run_db(1, 2);             // random ready

    sv0 = mem[0]; sv2 = mem[2];
    mem[0] = 12'd0;
    set_chk(0, 0);
    run_db(0, 0);             // empty stage
    mem[0] = sv0; mem[2] = sv2;

    // reset while beat 10 is on the bus, then restream
    build_model(0, 1, q, ec);
    @(negedge clk_fpga);
    start_a = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk_fpga);
      start_a = 1'b0;
      ready_a = 1'b1;
    end
    #1;
    chk("beat10_before_reset", {vld_a, beat_a}, {1'b1, q[9]});
    reset_fpga = 1'b1;
    @(negedge clk_fpga);
    #1;
    chk("reset_mid", outs_a, 84'h0);
    reset_fpga = 1'b0;
    ready_a = 1'b0;
    run_db(0, 0);

    mem[1] = 12'($urandom);
    for (int i = 0; i < 36; i++) mem[2 + i] = 12'($urandom);
    set_chk(0, 0);
    run_db(0, 2);

`ifdef DATABASE_CHECKSUM_EN
    set_chk(0, 1);            // wrong checksum word
    run_db(0, 0);
    set_chk(0, 0);
    run_db(0, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
